// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, scan-code prefixes and common key codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_KEY_UP     = 8'h75;
  localparam logic [7:0] PS2_KEY_DOWN   = 8'h72;
  localparam logic [7:0] PS2_KEY_ENTER  = 8'h5A;
  localparam logic [7:0] PS2_KEY_ESC    = 8'h76;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic ps2_odd_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: sync, falling-edge detect, 11-bit frame FSM, timeout; pulses byte/err combinationally
// on the stop-bit edge, no backpressure. PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, dat_s, fall;

  ps2_state_e  state_q, state_d;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [TW-1:0] tmo_q;
  logic        tmo_hit, par_ok;

  // Synchronisers idle high so reset release never looks like a falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], i_ps2_dat};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign dat_s   = dat_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_s;
  assign tmo_hit = (state_q != S_IDLE) && !fall && (tmo_q == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!dat_s) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          par_q <= 1'b0;
    else if (fall && state_q == S_PARITY)  par_q <= dat_s;
  end

  assign par_ok = ps2_odd_ok(shift_q, par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      if (state_q == S_IDLE || fall) tmo_q <= '0;
      else                           tmo_q <= tmo_q + TW'(1);
      if (fall) begin
        case (state_q)
          S_IDLE: bit_cnt_q <= '0;
          S_DATA: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_byte_vld = 1'b0;
    o_err      = 1'b0;
    if (tmo_hit) begin
      o_err = 1'b1;
    end else if (fall && state_q == S_STOP) begin
      if (dat_s && par_ok) o_byte_vld = 1'b1;
      else                 o_err      = 1'b1;
    end
  end

  assign o_byte = shift_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix handling on top of ps2_frame_rx, registered outputs one cycle after
// the stop-bit edge, no backpressure. PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_key,
  output logic       o_extended,
  output logic       o_key_valid,
  output logic       o_err
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame_rx (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .o_byte    (rx_byte),
    .o_byte_vld(rx_vld),
    .o_err     (rx_err)
  );

  logic [7:0] key_q, key_d;
  logic       ext_q, ext_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  logic       pend_ext_q, pend_ext_d;
  logic       pend_brk_q, pend_brk_d;

  always_comb begin
    key_d      = key_q;
    ext_d      = ext_q;
    vld_d      = 1'b0;
    err_d      = rx_err;
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
    if (rx_vld) begin
      if (rx_byte == PS2_EXT) begin
        pend_ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        pend_brk_d = 1'b1;
      end else begin
        if (!pend_brk_q) begin
          key_d = rx_byte;
          ext_d = pend_ext_q;
          vld_d = 1'b1;
        end else if (rx_byte == key_q) begin
          // Releasing some other key leaves the held key visible.
          key_d = 8'h00;
          ext_d = 1'b0;
        end
        pend_ext_d = 1'b0;
        pend_brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_q      <= 8'h00;
      ext_q      <= 1'b0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
    end else begin
      key_q      <= key_d;
      ext_q      <= ext_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      pend_ext_q <= pend_ext_d;
      pend_brk_q <= pend_brk_d;
    end
  end

  assign o_key       = key_q;
  assign o_extended  = ext_q;
  assign o_key_valid = vld_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random key traffic against a byte-level model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int TMO  = 300;
  localparam int HALF = 8;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key;
  logic       ext, kvld, err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_dat  (ps2_dat),
    .o_key      (key),
    .o_extended (ext),
    .o_key_valid(kvld),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int vld_seen = 0;
  int err_seen = 0;
  int exp_vld = 0;
  int exp_err = 0;

  logic [7:0] m_key;
  logic       m_ext, m_pend_ext, m_pend_brk;

  // Counting high cycles means a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kvld) vld_seen++;
      if (err)  err_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_key = 8'h00; m_ext = 1'b0; m_pend_ext = 1'b0; m_pend_brk = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_pend_ext = 1'b1;
    else if (b == 8'hF0) m_pend_brk = 1'b1;
    else begin
      if (!m_pend_brk) begin
        m_key = b; m_ext = m_pend_ext; exp_vld++;
      end else if (b == m_key) begin
        m_key = 8'h00; m_ext = 1'b0;
      end
      m_pend_ext = 1'b0; m_pend_brk = 1'b0;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2_dat = b;
    wait_cyc(HALF);
    @(negedge clk); ps2_clk = 1'b0;
    wait_cyc(HALF);
    @(negedge clk); ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    @(negedge clk); ps2_dat = 1'b1;
    wait_cyc(HALF);
    if (bad_stop || (PAR_EN && bad_par)) exp_err++;
    else model_byte(b);
  endtask

  task automatic settle_check(input string tag);
    wait_cyc(20);
    @(negedge clk);
    check({tag, ".key"}, {24'd0, key}, {24'd0, m_key});
    check({tag, ".ext"}, {31'd0, ext}, {31'd0, m_ext});
    check({tag, ".vld_cnt"}, vld_seen, exp_vld);
    check({tag, ".err_cnt"}, err_seen, exp_err);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    case ($urandom_range(0, 4))
      0:       c = PS2_KEY_UP;
      1:       c = PS2_KEY_DOWN;
      2:       c = PS2_KEY_ENTER;
      3:       c = PS2_KEY_ESC;
      default: c = 8'($urandom_range(1, 8'hDF));
    endcase
    return c;
  endfunction

  initial begin
    logic [7:0] c;
    model_reset();

    wait_cyc(3);
    @(negedge clk);
    check("rst.key", {24'd0, key}, 32'd0);
    check("rst.ext", {31'd0, ext}, 32'd0);
    check("rst.vld", {31'd0, kvld}, 32'd0);
    check("rst.err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(10);
    settle_check("rst_release");

    send_frame(8'h5A, 0, 0);                            settle_check("make_5a");
    send_frame(8'hF0, 0, 0); send_frame(8'h5A, 0, 0);   settle_check("brk_5a");

    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);   settle_check("ext_make_75");
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);                            settle_check("ext_brk_75");

    send_frame(8'h72, 1, 0);                            settle_check("bad_par_72");
    send_frame(8'h5A, 0, 1);                            settle_check("bad_stop_5a");

    // Partial frame: start plus four data bits, then the clock stops.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    wait_cyc(TMO - 60);
    @(negedge clk);
    check("tmo_not_yet", err_seen, exp_err);
    wait_cyc(150);
    exp_err++;
    settle_check("timeout");
    send_frame(8'h76, 0, 0);                            settle_check("after_tmo_76");

    send_frame(8'h75, 0, 0);                            settle_check("make_75");
    send_frame(8'hF0, 0, 0); send_frame(8'h72, 0, 0);   settle_check("brk_other_72");
    send_frame(8'h75, 0, 0);                            settle_check("typematic_75");

    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);                            settle_check("f0_e0_order");

    ps2_bit(1'b1);                                      settle_check("stray_start_1");

    send_frame(8'h72, 0, 0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    @(negedge clk); rst_n = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    check("midrst.key", {24'd0, key}, 32'd0);
    check("midrst.ext", {31'd0, ext}, 32'd0);
    check("midrst.vld", {31'd0, kvld}, 32'd0);
    check("midrst.err", {31'd0, err}, 32'd0);
    model_reset();
    ps2_dat = 1'b1;
    rst_n = 1'b1;
    wait_cyc(10);
    send_frame(8'h5A, 0, 0);                            settle_check("after_rst_5a");

    for (int n = 0; n < 40; n++) begin
      c = rand_code();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_frame(c, 0, 0);
        4, 5: begin send_frame(8'hE0, 0, 0); send_frame(c, 0, 0); end
        6: begin
          if ($urandom_range(0, 1) == 1 && m_key != 8'h00) c = m_key;
          send_frame(8'hF0, 0, 0); send_frame(c, 0, 0);
        end
        7: begin
          if ($urandom_range(0, 1) == 1 && m_key != 8'h00) c = m_key;
          if ($urandom_range(0, 1) == 1) begin send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); end
          else                           begin send_frame(8'hF0, 0, 0); send_frame(8'hE0, 0, 0); end
          send_frame(c, 0, 0);
        end
        8: send_frame(c, 1, 0);
        default: send_frame(c, 0, 1);
      endcase
      settle_check($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
